// File: rtl/damor_rbz_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : damor_rbz_div_pkg
// Brief    : Shared constants and state encoding for the 4x4 restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
package damor_rbz_div_pkg;

    localparam int OP_W       = 4;
    localparam int ITER_CNT_W = $clog2(OP_W);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/damor_rbz_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : damor_rbz_divider_if
// Brief    : Dedicated I/O buses of the divider: operands in, results out.
// Revision : 1.0 - initial release
// ============================================================================
interface damor_rbz_divider_if;
    import damor_rbz_div_pkg::*;

    logic [2*OP_W-1:0] ui_in;
    logic [2*OP_W-1:0] uo_out;

    modport master (output ui_in, input  uo_out);
    modport slave  (input  ui_in, output uo_out);

endinterface
`default_nettype wire

// File: rtl/damor_rbz_div_step.sv
`default_nettype none
// ============================================================================
// Module   : damor_rbz_div_step
// Brief    : One combinational restoring-division step (shift, trial subtract).
// Revision : 1.0 - initial release
// ============================================================================
module damor_rbz_div_step
    import damor_rbz_div_pkg::*;
(
    input  wire logic [OP_W:0]   i_rem,
    input  wire logic            i_bit,
    input  wire logic [OP_W-1:0] i_dvs,
    output logic      [OP_W:0]   o_rem,
    output logic                 o_q_bit
);

    logic [OP_W:0]   w_shift;
    logic [OP_W+1:0] w_diff;
    logic            w_unused;

    // Partial remainder stays below the divisor, so its MSB is always shifted out.
    assign w_unused = i_rem[OP_W];
    assign w_shift  = {i_rem[OP_W-1:0], i_bit};
    assign w_diff   = {1'b0, w_shift} - {2'b00, i_dvs};
    assign o_q_bit  = ~w_diff[OP_W+1];
    assign o_rem    = o_q_bit ? w_diff[OP_W:0] : w_shift;

endmodule
`default_nettype wire

// File: rtl/damor_rbz_divider.sv
`default_nettype none
// ============================================================================
// Module   : damor_rbz_divider
// Brief    : Free-running 4-bit iterative restoring divider, 6 clocks/result.
//            Optional macro SIGNED_DIV_EN selects two's-complement operands.
// Revision : 1.0 - initial release
// ============================================================================
module damor_rbz_divider
    import damor_rbz_div_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            rst_n,
    damor_rbz_divider_if.slave   bus
);

    state_t                r_state;
    state_t                w_state_next;
    logic [ITER_CNT_W-1:0] r_cnt;
    logic [OP_W-1:0]       r_dvd;
    logic [OP_W-1:0]       r_dvs;
    logic [OP_W-1:0]       r_quo;
    logic [OP_W:0]         r_rem;
    logic [2*OP_W-1:0]     r_uo_out;

    logic [OP_W-1:0]       w_a_mag;
    logic [OP_W-1:0]       w_b_mag;
    logic [OP_W:0]         w_rem_next;
    logic                  w_q_bit;
    logic [2*OP_W-1:0]     w_result;

    assign bus.uo_out = r_uo_out;

`ifdef SIGNED_DIV_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_a_neg;
    logic w_b_neg;

    assign w_a_neg = bus.ui_in[2*OP_W-1];
    assign w_b_neg = bus.ui_in[OP_W-1];
    // Magnitude of -8 is 4'b1000, which the unsigned core handles directly.
    assign w_a_mag = w_a_neg ? (OP_W'(0) - bus.ui_in[2*OP_W-1 -: OP_W])
                             : bus.ui_in[2*OP_W-1 -: OP_W];
    assign w_b_mag = w_b_neg ? (OP_W'(0) - bus.ui_in[OP_W-1:0])
                             : bus.ui_in[OP_W-1:0];

    always_comb begin
        w_result = '0;
        w_result[OP_W-1:0] = r_neg_r ? (OP_W'(0) - r_rem[OP_W-1:0]) : r_rem[OP_W-1:0];
        if (r_dvs == '0) begin
            w_result[2*OP_W-1 -: OP_W] = '1;
        end else begin
            w_result[2*OP_W-1 -: OP_W] = r_neg_q ? (OP_W'(0) - r_quo) : r_quo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == LOAD) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end
    end
`else
    assign w_a_mag  = bus.ui_in[2*OP_W-1 -: OP_W];
    assign w_b_mag  = bus.ui_in[OP_W-1:0];
    assign w_result = {r_quo, r_rem[OP_W-1:0]};
`endif

    damor_rbz_div_step u_step (
        .i_rem   (r_rem),
        .i_bit   (r_dvd[r_cnt]),
        .i_dvs   (r_dvs),
        .o_rem   (w_rem_next),
        .o_q_bit (w_q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD:    w_state_next = ITER;
            ITER:    if (r_cnt == '0) w_state_next = DONE;
            DONE:    w_state_next = LOAD;
            default: w_state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_uo_out <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_dvd <= w_a_mag;
                    r_dvs <= w_b_mag;
                    r_rem <= '0;
                    r_quo <= '0;
                    r_cnt <= ITER_CNT_W'(OP_W - 1);
                end
                ITER: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[OP_W-2:0], w_q_bit};
                    r_cnt <= r_cnt - 1'b1;
                end
                DONE: begin
                    r_uo_out <= w_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_damor_rbz_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_damor_rbz_divider
// Brief    : Self-checking bench for damor_rbz_divider (unsigned or SIGNED_DIV_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_damor_rbz_divider;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;

    damor_rbz_divider_if bus ();

    damor_rbz_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Expected {quotient, remainder} straight from the arithmetic definition.
    function automatic logic [7:0] model(input logic [7:0] v);
        logic [3:0] q;
        logic [3:0] r;
`ifdef SIGNED_DIV_EN
        logic signed [3:0] sa;
        logic signed [3:0] sb;
        int a, b, qi, ri;
        sa = v[7:4];
        sb = v[3:0];
        a  = sa;
        b  = sb;
        if (b == 0) begin
            qi = -1;
            ri = a;
        end else if (a == -8 && b == -1) begin
            qi = -8;
            ri = 0;
        end else begin
            qi = a / b;
            ri = a % b;
        end
        q = qi[3:0];
        r = ri[3:0];
`else
        int a, b;
        a = int'(v[7:4]);
        b = int'(v[3:0]);
        if (b == 0) begin
            q = 4'hF;
            r = v[7:4];
        end else begin
            q = 4'(a / b);
            r = 4'(a % b);
        end
`endif
        return {q, r};
    endfunction

    initial begin
        logic [7:0] vec [7];
        logic [7:0] v;
        logic [7:0] prev;
        logic       bad;

        vec = '{8'hD3, 8'h2F, 8'hF1, 8'h70, 8'h00, 8'h93, 8'h8F};

        bus.ui_in = 8'hFF;
        rst_n     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset", bus.uo_out, 8'h00);
        end

        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_reset_hold", bus.uo_out, 8'h00);
        end
        tick();
        check("first_result", bus.uo_out, model(8'hFF));

        for (int k = 0; k < 7; k++) begin
            bus.ui_in = vec[k];
            for (int i = 0; i < 12; i++) tick();
            check("directed", bus.uo_out, model(vec[k]));
        end

        for (int k = 0; k < 12; k++) begin
            v = 8'($urandom());
            bus.ui_in = v;
            for (int i = 0; i < 12; i++) tick();
            check("random", bus.uo_out, model(v));
        end

        // Output may move only on edges 6, 12, 18, ... after reset release.
        prev = bus.uo_out;
        for (int i = 0; i < 32; i++) begin
            bus.ui_in = (i < 20) ? 8'($urandom()) : 8'h93;
            tick();
            bad = (bus.uo_out !== prev) && (cyc % 6 != 0);
            check("stable_edge", {7'b0, bad}, 8'h00);
            prev = bus.uo_out;
        end
        check("held_93", bus.uo_out, model(8'h93));

        for (int i = 0; i < 6 && (cyc % 6 != 2); i++) tick();
        check("pre_abort", bus.uo_out, model(8'h93));
        rst_n = 1'b0;
        tick();
        check("midop_reset", bus.uo_out, 8'h00);
        rst_n     = 1'b1;
        bus.ui_in = 8'hD3;
        cyc       = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_hold", bus.uo_out, 8'h00);
        end
        tick();
        check("after_abort", bus.uo_out, model(8'hD3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
